// File: rtl/sm4_serial_ctrl.sv
// sm4_serial_ctrl: phase sequencer for the bit-serial SM4 datapath (LOAD, ROUND, INV, OUT).
// Optional SM4_DECRYPT_EN adds a decrypt input that reverses the round index order.
module sm4_serial_ctrl #(
    parameter int ROUNDS   = 32,
    parameter int BLK_BITS = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef SM4_DECRYPT_EN
    input  logic       decrypt,
`endif
    output logic       din_ready,
    output logic [2:0] ctrl_s,
    output logic       ctrl_rt_s,
    output logic       done,
    output logic       busy,
    output logic [4:0] round_idx,
    output logic [4:0] bit_idx,
    output logic       ks_en
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, INV, OUT} state_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);
    localparam logic [6:0] LAST_CNT = 7'(ROUNDS - 1);
    localparam logic [6:0] BLK_LAST = 7'(BLK_BITS - 1);

    state_t     state, state_n;
    logic [6:0] cnt, cnt_n;
    logic [4:0] bit_n, round_n;
    logic       dec, dec_n, dec_in;
    logic [2:0] rnd_code, ctrl_n;
    logic       rt_n;

`ifdef SM4_DECRYPT_EN
    assign dec_in = decrypt;
`else
    assign dec_in = 1'b0;
`endif

    // cnt is the LOAD/OUT bit counter and, during ROUND, the count of completed rounds
    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        round_n = '0;
        dec_n   = dec;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    dec_n   = dec_in;
                end
            end
            LOAD: begin
                if (cnt == BLK_LAST) begin
                    state_n = ROUND;
                    round_n = dec ? LAST_RND : 5'd0;
                end else begin
                    state_n = LOAD;
                    cnt_n   = cnt + 7'd1;
                end
            end
            ROUND: begin
                state_n = ROUND;
                cnt_n   = cnt;
                round_n = round_idx;
                if (bit_idx == 5'd31) begin
                    if (cnt == LAST_CNT) begin
                        state_n = INV;
                        cnt_n   = '0;
                        round_n = '0;
                    end else begin
                        cnt_n   = cnt + 7'd1;
                        round_n = dec ? round_idx - 5'd1 : round_idx + 5'd1;
                    end
                end
            end
            INV: state_n = (bit_idx == 5'd31) ? OUT : INV;
            OUT: begin
                if (cnt != BLK_LAST) begin
                    state_n = OUT;
                    cnt_n   = cnt + 7'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bit_n    = (state == IDLE || state_n == IDLE) ? 5'd0 : bit_idx + 5'd1;
        rnd_code = (bit_n < 5'd2)  ? 3'd1 :
                   (bit_n < 5'd10) ? 3'd3 :
                   (bit_n < 5'd18) ? 3'd2 :
                   (bit_n < 5'd24) ? 3'd6 : 3'd7;
        ctrl_n   = (state_n == LOAD)  ? 3'd0 :
                   (state_n == ROUND) ? rnd_code :
                   (state_n == INV)   ? 3'd5 : 3'd4;
        // the first round executed has no earlier transform output to fold back in
        rt_n     = (state_n == ROUND) && (bit_n <= 5'd7) &&
                   (dec_n ? (round_n != LAST_RND) : (round_n != 5'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dec       <= 1'b0;
            bit_idx   <= '0;
            round_idx <= '0;
            ctrl_s    <= 3'd4;
            ctrl_rt_s <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b0;
            ks_en     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dec       <= dec_n;
            bit_idx   <= bit_n;
            round_idx <= round_n;
            ctrl_s    <= ctrl_n;
            ctrl_rt_s <= rt_n;
            done      <= (state_n == OUT);
            busy      <= (state_n != IDLE);
            din_ready <= (state_n == LOAD);
            ks_en     <= (state_n == ROUND);
        end
    end
endmodule

// File: tb/tb_sm4_serial_ctrl.sv
// tb_sm4_serial_ctrl: directed bench; expected outputs derived from the cycle offset within a block.
module tb_sm4_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, decrypt;
    logic       din_ready, ctrl_rt_s, done, busy, ks_en;
    logic [2:0] ctrl_s;
    logic [4:0] round_idx, bit_idx;
    int         checks = 0;
    int         errors = 0;

    sm4_serial_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SM4_DECRYPT_EN
        .decrypt(decrypt),
`endif
        .din_ready(din_ready), .ctrl_s(ctrl_s), .ctrl_rt_s(ctrl_rt_s), .done(done),
        .busy(busy), .round_idx(round_idx), .bit_idx(bit_idx), .ks_en(ks_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ctrl_s"}, 32'(ctrl_s), 4);
        check({tag, ".rt"}, 32'(ctrl_rt_s), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".din_ready"}, 32'(din_ready), 0);
        check({tag, ".round_idx"}, 32'(round_idx), 0);
        check({tag, ".bit_idx"}, 32'(bit_idx), 0);
        check({tag, ".ks_en"}, 32'(ks_en), 0);
    endtask

    function automatic int round_code(input int b);
        return b < 2 ? 1 : b < 10 ? 3 : b < 18 ? 2 : b < 24 ? 6 : 7;
    endfunction

    // entered just after the edge that sampled start: observes LOAD cycle 0 first
    task automatic run_block(input bit dec, input int abort_at);
        for (int k = 0; k < 1312; k++) begin
            int r, b, e_ctrl, e_rt, e_rnd;
            bit ld, rd, iv, ot;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_idle("abort");
                step;
                check_idle("abort_hold");
                rst = 1'b0;
                step;
                check_idle("abort_rel");
                return;
            end
            ld = k < 128;
            rd = k >= 128 && k < 1152;
            iv = k >= 1152 && k < 1184;
            ot = k >= 1184;
            b = k % 32;
            r = rd ? (k - 128) / 32 : 0;
            e_rnd = rd ? (dec ? 31 - r : r) : 0;
            e_ctrl = ld ? 0 : rd ? round_code(b) : iv ? 5 : 4;
            e_rt = (rd && r > 0 && b <= 7) ? 1 : 0;
            check("ctrl_s", 32'(ctrl_s), 32'(e_ctrl));
            check("ctrl_rt_s", 32'(ctrl_rt_s), 32'(e_rt));
            check("round_idx", 32'(round_idx), 32'(e_rnd));
            check("bit_idx", 32'(bit_idx), 32'(b));
            check("din_ready", 32'(din_ready), 32'(ld));
            check("ks_en", 32'(ks_en), 32'(rd));
            check("done", 32'(done), 32'(ot));
            check("busy", 32'(busy), 1);
            start = (k == 500 || k == 1311);
            step;
        end
        check_idle("end");
        start = 1'b0;
        step;
        check_idle("end_hold");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        decrypt = 1'b0;
        repeat (3) step;
        check_idle("reset");
        rst = 1'b0;
        step;
        run_block(1'b0, -1);
        repeat (8) step;
        check_idle("idle_gap");
        start = 1'b1;
        step;
        run_block(1'b0, 600);
        start = 1'b1;
        step;
        run_block(1'b0, -1);
`ifdef SM4_DECRYPT_EN
        decrypt = 1'b1;
        start = 1'b1;
        step;
        decrypt = 1'b0;
        run_block(1'b1, -1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
